register_file_mp: RTL and testbench
===================================

# register_file_mp

Parametrised multi-ported register file with write-port priority, a per-register busy scoreboard and optional same-cycle write-to-read forwarding. It sits in the decode/writeback boundary of the core. Decode issues read addresses and reserves destination registers. One or more writeback paths retire results into it. Entry 0 is hardwired to zero.

## Interface
Parameters:
- `XLEN`, 32, data width of each register.
- `DEPTH`, 32, number of registers; power of two, ≥ 2. `AW` = $clog2(DEPTH).
- `NUM_RD`, 2, number of combinational read ports.
- `NUM_WR`, 2, number of write ports.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rd_addr`  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- `rd_data`  out  NUM_RD*XLEN  read data; port i at [i*XLEN +: XLEN].
- `rd_busy`  out  NUM_RD  scoreboard bit of the register addressed by each read port.
- `wr_en`  in  NUM_WR  per-port write enable.
- `wr_addr`  in  NUM_WR*AW  write addresses.
- `wr_data`  in  NUM_WR*XLEN  write data.
- `rsv_en`  in  1  marks `rsv_addr` busy (destination reserved at issue).
- `rsv_addr`  in  AW  register to reserve.
- `busy_vec`  out  DEPTH  full scoreboard; bit 0 always 0.
- `wr_coll`  out  1  sticky error: two enabled write ports hit the same nonzero address in one cycle.

## Operation
- **Storage:** DEPTH × XLEN flops plus a DEPTH-bit busy vector and the `wr_coll` flop.
- **Reset:** async assertion clears every register, busy bit and `wr_coll` to 0 while `reset` is high. Writes and reservations are ignored during reset.
- **Writes:**
  - Port j writes on a rising edge when `wr_en[j]` = 1 and its address ≠ 0.
  - Writes to address 0 are discarded, and register 0 always reads 0.
  - If several enabled ports target the same address, the highest-indexed port wins.
- **Collision flag:** `wr_coll` sets one edge after any same-address collision with address ≠ 0. It stays set until reset. Address-0 collisions do not set it.
- **Scoreboard:**
  - On an edge, an enabled write to nonzero address a clears busy[a].
  - `rsv_en` with `rsv_addr` ≠ 0 sets busy[`rsv_addr`].
  - Reserve and write to the same address in the same cycle: reserve wins and busy stays 1, because the newer producer is pending.
  - `rsv_addr` = 0 has no effect.
- **Reads:**
  - `rd_data[i]` = register[`rd_addr[i]`], combinational.
  - `rd_busy[i]` = busy[`rd_addr[i]`], combinational.
  - Address 0 returns data 0 and busy 0.
- **Forwarding:** applies only when compiled in; see Configuration.

## Timing
- Write latency is 1 cycle. Data written at edge N is visible on `rd_data` after edge N.
- Busy set or clear takes effect after the edge. `busy_vec` and `rd_busy` update in the same cycle as each other.
- Read paths are purely combinational from `rd_addr` and state (plus `wr_*`/`rsv_*` when forwarding is on). There is no read latency.
- `wr_coll` asserts in the cycle after the colliding edge.
- Reset mid-operation: outputs go to 0 asynchronously, with no dependence on `clk`. The first write is accepted on the first edge after `reset` deasserts.
- Output values under reset: `rd_data` all 0, `rd_busy` 0, `busy_vec` 0, `wr_coll` 0.

## Configuration
Macro: `REGFILE_BYPASS_EN`.

Defined:
- If any enabled write port targets `rd_addr[i]` ≠ 0 in the current cycle, `rd_data[i]` returns that write's `wr_data`, using the highest-index matching port.
- `rd_busy[i]` returns 0 in that case, unless `rsv_en` targets the same address in the same cycle.

Undefined:
- Reads return only stored state; the same-cycle write becomes visible after the edge.
- The bypass muxes are not synthesised.

## Test plan
- **Reset and zero register:** assert `reset` asynchronously mid-cycle after loading r5 = 0xDEADBEEF → `rd_data` for r5 reads 0 immediately. Then write r0 = 0x1234 → r0 reads 0.
- **Write priority and collision:**
  - Ports 0 and 1 both write r7 (0x11, 0x22) → r7 = 0x22 next cycle and `wr_coll` = 1; it stays 1 until reset.
  - Both ports writing r0 → `wr_coll` stays 0.
- **Scoreboard:**
  - `rsv_en` r3 → `busy_vec[3]` = 1 next cycle. Write r3 = 0x55 → busy clears and r3 reads 0x55.
  - Reserve and write r3 in the same cycle → busy stays 1.
- **Multi-port read:** NUM_RD = 3. Load r1 = 1, r2 = 2, r31 = 0xFFFF_FFFF and read all three in the same cycle → `rd_data` = {0xFFFF_FFFF, 2, 1}.
- **Bypass:** write r9 = 0xA5A5 while reading r9 in the same cycle.
  - With `REGFILE_BYPASS_EN`: `rd_data` = 0xA5A5 and `rd_busy` = 0 in the same cycle.
  - Without it: the old value is returned, and 0xA5A5 appears the next cycle.
- **Parameter sweep:** DEPTH = 8, XLEN = 16. Write r7 = 0xBEEF → reads 0xBEEF, and `busy_vec` width is 8.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-ported register file with highest-port write
// priority, a per-register busy scoreboard and a sticky write-collision flag.
// Entry 0 is hardwired to zero and is never marked busy.
// Optional macro REGFILE_BYPASS_EN: a read that hits a same-cycle write
// returns the write data, and that register reads not-busy unless it is
// also being reserved in the same cycle.
module register_file_mp #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned NUM_WR = 2,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*XLEN-1:0]   rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*XLEN-1:0]   wr_data,
   input  logic                     rsv_en,
   input  logic [AW-1:0]            rsv_addr,
   output logic [DEPTH-1:0]         busy_vec,
   output logic                     wr_coll
);

   logic [DEPTH-1:0][XLEN-1:0] mem;
   logic [DEPTH-1:0][XLEN-1:0] mem_nxt;
   logic [DEPTH-1:0]           busy;
   logic [DEPTH-1:0]           busy_nxt;
   logic                       coll_now;
   logic [AW-1:0]              ra;
   logic [XLEN-1:0]            rdat;
   logic                       rbusy;
   logic                       byp;

   // Next register contents; ascending port order lets the highest port win.
   always_comb begin
      mem_nxt = mem;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != '0))
            mem_nxt[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
      mem_nxt[0] = '0;
   end

   // Next scoreboard: writes clear, then a reservation sets (newer producer wins).
   always_comb begin
      busy_nxt = busy;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         if (wr_en[j])
            busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (rsv_en)
         busy_nxt[rsv_addr] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Detect two enabled write ports hitting the same nonzero address.
   always_comb begin
      coll_now = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
         for (int unsigned k = j + 1; k < NUM_WR; k++) begin
            if (wr_en[j] && wr_en[k] &&
                (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW]) &&
                (wr_addr[j*AW +: AW] != '0))
               coll_now = 1'b1;
         end
      end
   end

   // State registers; asynchronous reset clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem     <= '0;
         busy    <= '0;
         wr_coll <= 1'b0;
      end else begin
         mem  <= mem_nxt;
         busy <= busy_nxt;
         if (coll_now)
            wr_coll <= 1'b1;
      end
   end

   assign busy_vec = busy;

   // Combinational read ports, with optional same-cycle write forwarding.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      ra      = '0;
      rdat    = '0;
      rbusy   = 1'b0;
      byp     = 1'b0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         ra    = rd_addr[i*AW +: AW];
         rdat  = mem[ra];
         rbusy = busy[ra];
         byp   = 1'b0;
`ifdef REGFILE_BYPASS_EN
         for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
               rdat = wr_data[j*XLEN +: XLEN];
               byp  = 1'b1;
            end
         end
         if (byp)
            rbusy = rsv_en && (rsv_addr == ra);
`endif
         if (ra == '0) begin
            rdat  = '0;
            rbusy = 1'b0;
         end
         rd_data[i*XLEN +: XLEN] = rdat;
         rd_busy[i]              = rbusy;
      end
   end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: a 3-read/2-write 32x32 instance and
// an 8x16 instance, both sharing clock and reset.
module tb_register_file_mp;

   logic        clk;
   logic        reset;

   // main instance: XLEN=32, DEPTH=32, NUM_RD=3, NUM_WR=2
   logic [14:0] rd_addr;
   logic [95:0] rd_data;
   logic [2:0]  rd_busy;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [31:0] busy_vec;
   logic        wr_coll;

   // small instance: XLEN=16, DEPTH=8
   logic [5:0]  s_rd_addr;
   logic [31:0] s_rd_data;
   logic [1:0]  s_rd_busy;
   logic [1:0]  s_wr_en;
   logic [5:0]  s_wr_addr;
   logic [31:0] s_wr_data;
   logic        s_rsv_en;
   logic [2:0]  s_rsv_addr;
   logic [7:0]  s_busy_vec;
   logic        s_wr_coll;

   int total = 0;
   int bad   = 0;

   register_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(3), .NUM_WR(2)) dut (
      .clk(clk), .reset(reset),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_vec(busy_vec), .wr_coll(wr_coll)
   );

   register_file_mp #(.XLEN(16), .DEPTH(8), .NUM_RD(2), .NUM_WR(2)) dut_s (
      .clk(clk), .reset(reset),
      .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
      .busy_vec(s_busy_vec), .wr_coll(s_wr_coll)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en  = '0;
      rsv_en = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      rsv_en = 1'b0; rsv_addr = '0;
      s_rd_addr = '0; s_wr_en = '0; s_wr_addr = '0; s_wr_data = '0;
      s_rsv_en = 1'b0; s_rsv_addr = '0;
      #2;
      check("reset_rd_data", {32'h0, rd_data[31:0]}, 64'h0);
      check("reset_busy_vec", {32'h0, busy_vec}, 64'h0);
      check("reset_wr_coll", {63'h0, wr_coll}, 64'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // load r5, then async reset mid-cycle
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
      tick(); idle();
      rd_addr = {5'd0, 5'd0, 5'd5};
      #1;
      check("r5_loaded", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
      #2 reset = 1'b1;
      #1;
      check("r5_async_reset", {32'h0, rd_data[31:0]}, 64'h0);
      #1 reset = 1'b0;

      // write r0 is discarded
      wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'h1234};
      tick(); idle();
      rd_addr = {5'd0, 5'd0, 5'd0};
      #1;
      check("r0_zero", {32'h0, rd_data[31:0]}, 64'h0);

      // both ports on r0: no collision
      wr_en = 2'b11; wr_addr = {5'd0, 5'd0}; wr_data = {32'h77, 32'h66};
      tick(); idle();
      check("coll_r0", {63'h0, wr_coll}, 64'h0);

      // both ports on r7: port 1 wins, collision sticks
      wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'h22, 32'h11};
      tick(); idle();
      rd_addr = {5'd0, 5'd0, 5'd7};
      #1;
      check("r7_prio", {32'h0, rd_data[31:0]}, 64'h22);
      check("coll_set", {63'h0, wr_coll}, 64'h1);
      tick(); tick();
      check("coll_sticky", {63'h0, wr_coll}, 64'h1);

      // reserve r3, then write clears busy
      rsv_en = 1'b1; rsv_addr = 5'd3;
      tick(); idle();
      rd_addr = {5'd0, 5'd0, 5'd3};
      #1;
      check("busy_vec_r3", {32'h0, busy_vec}, 64'h8);
      check("rd_busy_r3", {61'h0, rd_busy}, 64'h1);
      wr_en = 2'b10; wr_addr = {5'd3, 5'd0}; wr_data = {32'h55, 32'h0};
      tick(); idle();
      check("busy_clr_r3", {32'h0, busy_vec}, 64'h0);
      check("r3_data", {32'h0, rd_data[31:0]}, 64'h55);

      // reserve and write r3 same cycle: stays busy, data still written
      rsv_en = 1'b1; rsv_addr = 5'd3;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h66};
      tick(); idle();
      check("rsv_wins", {32'h0, busy_vec}, 64'h8);
      check("r3_data2", {32'h0, rd_data[31:0]}, 64'h66);

      // three-port read
      wr_en = 2'b11; wr_addr = {5'd2, 5'd1}; wr_data = {32'h2, 32'h1};
      tick();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd31}; wr_data = {32'h0, 32'hFFFF_FFFF};
      tick(); idle();
      rd_addr = {5'd31, 5'd2, 5'd1};
      #1;
      check("mrd_p0", {32'h0, rd_data[31:0]}, 64'h1);
      check("mrd_p1", {32'h0, rd_data[63:32]}, 64'h2);
      check("mrd_p2", {32'h0, rd_data[95:64]}, 64'hFFFF_FFFF);

      // bypass: r9 reserved, then written while read
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick(); idle();
      rd_addr = {5'd0, 5'd0, 5'd9};
      wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'hA5A5};
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data", {32'h0, rd_data[31:0]}, 64'hA5A5);
      check("byp_busy", {61'h0, rd_busy}, 64'h0);
`else
      check("byp_data", {32'h0, rd_data[31:0]}, 64'h0);
      check("byp_busy", {61'h0, rd_busy}, 64'h1);
`endif
      tick(); idle();
      #1;
      check("r9_after", {32'h0, rd_data[31:0]}, 64'hA5A5);
      check("r9_busy_after", {61'h0, rd_busy}, 64'h0);

      // small instance: DEPTH=8, XLEN=16
      s_wr_en = 2'b01; s_wr_addr = {3'd0, 3'd7}; s_wr_data = {16'h0, 16'hBEEF};
      tick();
      s_wr_en = '0;
      s_rsv_en = 1'b1; s_rsv_addr = 3'd7;
      s_rd_addr = {3'd0, 3'd7};
      #1;
      check("s_r7", {48'h0, s_rd_data[15:0]}, 64'hBEEF);
      tick();
      s_rsv_en = 1'b0;
      check("s_busy_vec", {56'h0, s_busy_vec}, 64'h80);

      // final reset clears everything
      reset = 1'b1;
      #1;
      check("final_coll", {63'h0, wr_coll}, 64'h0);
      check("final_r7", {32'h0, rd_data[31:0]}, 64'h0);
      check("final_s_busy", {56'h0, s_busy_vec}, 64'h0);
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
